// File: rtl/rv32i_types.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the NOP control word that a flush loads, and the load-use hazard test.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    DMEM_WAIT = 2'd2,
    BOTH_WAIT = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic       jump;
    logic       branch;
  } ctrl_word_t;

  localparam ctrl_word_t NOP_CTRL = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, dmem_read: 1'b0,
    dmem_write: 1'b0, reg_write: 1'b0, jump: 1'b0, branch: 1'b0
  };

  // x0 is hard-wired, so a load targeting it never creates a dependency
  function automatic logic load_use_hazard(input logic [4:0] ex_rd, input logic ex_dmem_read,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
    return ex_dmem_read & (ex_rd != 5'd0) & ((ex_rd == rs1) | (ex_rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; the clear wins over an increment.
module sat_counter
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stalls, redirect flushes,
// load-use bubbles, a sticky memory-timeout flag and performance counters.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_dmem_read,
  input  logic             ex_redirect,
  input  logic             mem_dmem_req,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             cnt_clear,
  output logic             imem_read,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       state,
  output logic             hang,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  hz_state_e   state_d, state_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic        hang_d, hang_q;
  logic        imem_wait, dmem_wait, mem_stall, load_use;
  logic        do_stall, do_redirect, do_bubble;

  assign imem_wait   = ~imem_resp;
  assign dmem_wait   = mem_dmem_req & ~dmem_resp;
  assign mem_stall   = imem_wait | dmem_wait;
  assign load_use    = load_use_hazard(ex_rd, ex_dmem_read, id_rs1, id_rs2);

  // Held redirect/load-use needs no storage: EX is frozen during a stall, so the
  // same inputs are still present in the first cycle the stall clears.
  assign do_stall    = ~rst & mem_stall;
  assign do_redirect = ~rst & ~mem_stall & ex_redirect;
  assign do_bubble   = ~rst & ~mem_stall & ~ex_redirect & load_use;

  // state, wait timer and hang flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= {WAIT_W{1'b0}};
      hang_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hang_q     <= hang_d;
    end
  end

  // next state, wait timer (saturates at TIMEOUT) and sticky hang
  always_comb begin
    state_d = RUN;
    case ({imem_wait, dmem_wait})
      2'b11:   state_d = BOTH_WAIT;
      2'b10:   state_d = IMEM_WAIT;
      2'b01:   state_d = DMEM_WAIT;
      default: state_d = RUN;
    endcase
    wait_cnt_d = {WAIT_W{1'b0}};
    if (state_q == RUN) begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    hang_d = hang_q | (wait_cnt_d == WAIT_W'(TIMEOUT));
  end

  // pipeline enables and flushes, priority reset > stall > redirect > load-use
  always_comb begin
    imem_read   = 1'b1;
    load_pc     = 1'b1;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      imem_read   = 1'b0;
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b00000;
      {flush_if_id, flush_id_ex} = 2'b11;
    end else if (mem_stall) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b00000;
    end else if (ex_redirect) begin
      {flush_if_id, flush_id_ex} = 2'b11;
    end else if (load_use) begin
      {load_pc, load_if_id} = 2'b00;
      flush_id_ex = 1'b1;
    end else begin
      flush_if_id = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(do_stall), .clr(cnt_clear), .cnt(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(do_bubble), .clr(cnt_clear), .cnt(bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(do_redirect), .clr(cnt_clear), .cnt(flush_cnt)
  );

  assign state = state_q;
  assign hang  = hang_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control words and next states
// are queued as each step is driven and compared when the step is observed.
module tb_pipeline_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  // {imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [7:0] CTL_RST    = 8'b0_00000_11;
  localparam logic [7:0] CTL_RUN    = 8'b1_11111_00;
  localparam logic [7:0] CTL_STALL  = 8'b1_00000_00;
  localparam logic [7:0] CTL_REDIR  = 8'b1_11111_11;
  localparam logic [7:0] CTL_BUBBLE = 8'b1_00111_01;

  localparam logic [1:0] S_RUN = 2'd0, S_IMEM = 2'd1, S_DMEM = 2'd2, S_BOTH = 2'd3;

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_dmem_read, ex_redirect, mem_dmem_req, imem_resp, dmem_resp, cnt_clear;
  logic imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, hang;
  logic [1:0] state;
  logic [TB_CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [7:0] ctl;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_dmem_read(ex_dmem_read), .ex_redirect(ex_redirect), .mem_dmem_req(mem_dmem_req),
    .imem_resp(imem_resp), .dmem_resp(dmem_resp), .cnt_clear(cnt_clear),
    .imem_read(imem_read), .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .state(state), .hang(hang),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the inputs now applied, then observe this cycle's
  // control outputs before the edge and the registered state after it.
  task automatic step(input string tag, input logic [7:0] ectl, input logic [1:0] est);
    exp_t e;
    logic [7:0] ctl_obs;
    sbq.push_back('{tag: tag, ctl: ectl, st: est});
    #2;
    e = sbq.pop_front();
    ctl_obs = {imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex};
    chk({e.tag, "_ctl"}, 32'(ctl_obs), 32'(e.ctl));
    @(posedge clk);
    #1;
    chk({e.tag, "_state"}, 32'(state), 32'(e.st));
  endtask

  initial begin
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_dmem_read = 1'b0; ex_redirect = 1'b0; mem_dmem_req = 1'b0;
    imem_resp = 1'b1; dmem_resp = 1'b1; cnt_clear = 1'b0;
    @(posedge clk); #1;

    // reset dominates even a pending memory wait
    step("rst", CTL_RST, S_RUN);
    imem_resp = 1'b0;
    step("rst_imem_wait", CTL_RST, S_RUN);
    imem_resp = 1'b1;
    chk("rst_hang", 32'(hang), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    rst = 1'b0;
    step("idle", CTL_RUN, S_RUN);

    // load-use on rs1, then on rs2
    id_rs1 = 5'd5; ex_rd = 5'd5; ex_dmem_read = 1'b1;
    step("lu_rs1", CTL_BUBBLE, S_RUN);
    ex_dmem_read = 1'b0;
    step("lu_rs1_after", CTL_RUN, S_RUN);
    chk("bubble_cnt_1", 32'(bubble_cnt), 32'd1);
    id_rs1 = 5'd0; id_rs2 = 5'd7; ex_rd = 5'd7; ex_dmem_read = 1'b1;
    step("lu_rs2", CTL_BUBBLE, S_RUN);
    chk("bubble_cnt_2", 32'(bubble_cnt), 32'd2);

    // no hazard through x0 or from a non-load
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_dmem_read = 1'b1;
    step("lu_x0", CTL_RUN, S_RUN);
    id_rs1 = 5'd5; ex_rd = 5'd5; ex_dmem_read = 1'b0;
    step("alu_dep", CTL_RUN, S_RUN);
    chk("bubble_cnt_hold", 32'(bubble_cnt), 32'd2);
    id_rs1 = 5'd0; ex_rd = 5'd0;

    // three-cycle data memory wait
    mem_dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) step("dmem_wait", CTL_STALL, S_DMEM);
    dmem_resp = 1'b1;
    step("dmem_done", CTL_RUN, S_RUN);
    chk("stall_cnt_3", 32'(stall_cnt), 32'd3);

    // instruction wait, then both waiting
    mem_dmem_req = 1'b0; imem_resp = 1'b0;
    step("imem_wait", CTL_STALL, S_IMEM);
    mem_dmem_req = 1'b1; dmem_resp = 1'b0;
    step("both_wait", CTL_STALL, S_BOTH);
    mem_dmem_req = 1'b0; dmem_resp = 1'b1; imem_resp = 1'b1;
    step("both_done", CTL_RUN, S_RUN);
    chk("stall_cnt_5", 32'(stall_cnt), 32'd5);

    cnt_clear = 1'b1;
    step("clear", CTL_RUN, S_RUN);
    cnt_clear = 1'b0;
    chk("clear_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("clear_bubble_cnt", 32'(bubble_cnt), 32'd0);

    // redirect plus load-use held through an instruction wait
    ex_redirect = 1'b1; id_rs1 = 5'd5; ex_rd = 5'd5; ex_dmem_read = 1'b1; imem_resp = 1'b0;
    for (int i = 0; i < 2; i++) step("held_redir", CTL_STALL, S_IMEM);
    imem_resp = 1'b1;
    step("redir", CTL_REDIR, S_RUN);
    ex_redirect = 1'b0; id_rs1 = 5'd0; ex_rd = 5'd0; ex_dmem_read = 1'b0;
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("redir_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("redir_stall_cnt", 32'(stall_cnt), 32'd2);

    // clear overrides a coincident increment
    cnt_clear = 1'b1; ex_redirect = 1'b1;
    step("clear_redir", CTL_REDIR, S_RUN);
    cnt_clear = 1'b0; ex_redirect = 1'b0;
    chk("clear_over_inc", 32'(flush_cnt), 32'd0);

    // memory timeout: hang sets at the end of the fifth wait cycle and sticks
    mem_dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step("hang_wait", CTL_STALL, S_DMEM);
      chk($sformatf("hang_cyc%0d", k), 32'(hang), (k >= 5) ? 32'd1 : 32'd0);
    end
    dmem_resp = 1'b1;
    step("hang_resp", CTL_RUN, S_RUN);
    chk("hang_sticky", 32'(hang), 32'd1);

    // stall counter saturation, then clear during a stall
    dmem_resp = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step("sat_wait", CTL_STALL, S_DMEM);
      if (i == 8) chk("stall_cnt_14", 32'(stall_cnt), 32'd14);
    end
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    step("sat_hold", CTL_STALL, S_DMEM);
    chk("stall_cnt_sat_hold", 32'(stall_cnt), 32'd15);
    cnt_clear = 1'b1;
    step("sat_clear", CTL_STALL, S_DMEM);
    cnt_clear = 1'b0;
    chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);

    // reset mid-stall abandons the wait and clears hang
    rst = 1'b1;
    step("rst_mid_stall", CTL_RST, S_RUN);
    chk("rst_clears_hang", 32'(hang), 32'd0);
    rst = 1'b0;
    step("post_rst_wait", CTL_STALL, S_DMEM);
    dmem_resp = 1'b1; mem_dmem_req = 1'b0;
    step("post_rst_run", CTL_RUN, S_RUN);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
